// File: rtl/color_pkg.sv
// Shared types and constants for the gamma LUT stage: channel codes, table geometry,
// sequencer states and the pipeline stage record.
package color_pkg;

  localparam int unsigned LUT_DEPTH = 256;
  localparam int unsigned LUT_W     = 8;
  localparam int unsigned LUT_AW    = $clog2(LUT_DEPTH);
  localparam int unsigned NUM_CH    = 3;
  localparam int unsigned PIX_W     = NUM_CH * LUT_W;

  typedef enum logic [1:0] {
    CH_R   = 2'd0,
    CH_G   = 2'd1,
    CH_B   = 2'd2,
    CH_ALL = 2'd3
  } lut_ch_e;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_PEND
  } lut_state_e;

  // One pipeline stage: sideband, passthrough flag, bank select and pixel.
  typedef struct packed {
    logic             vld;
    logic             usr;
    logic             lst;
    logic             byp;
    logic             sel;
    logic [PIX_W-1:0] dat;
  } pix_stage_t;

  function automatic logic ch_hit(input logic [1:0] sel, input int unsigned ch);
    return (sel == CH_ALL) || (sel == 2'(ch));
  endfunction

endpackage

// File: rtl/rgb_gamma_lut_if.sv
// AXI-stream style pixel bus (no tready) shared by the input and output of the LUT stage.
interface rgb_gamma_lut_if;
  logic        tvalid;
  logic        tuser;
  logic        tlast;
  logic [23:0] tdata;

  modport master (output tvalid, tuser, tlast, tdata);
  modport slave  (input  tvalid, tuser, tlast, tdata);
endinterface

// File: rtl/lut_bank.sv
// 256x8 simple dual-port table: synchronous write, read-first, registered read data.
module lut_bank
  import color_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [LUT_AW-1:0] waddr_i,
  input  logic [LUT_W-1:0]  wdata_i,
  input  logic [LUT_AW-1:0] raddr_i,
  output logic [LUT_W-1:0]  rdata_o
);

  logic [LUT_W-1:0] mem_q [LUT_DEPTH];
  logic [LUT_W-1:0] rdata_d, rdata_q;

  // Sampled before the write lands, so a same-address collision returns the old entry.
  always_comb rdata_d = mem_q[raddr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= rdata_d;
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/rgb_gamma_lut.sv
// Per-channel 8-bit gamma/tone LUT on an RGB pixel stream, 2-cycle latency.
// Define GAMMA_LUT_SHADOW_EN for double-buffered tables swapped at start of frame.
module rgb_gamma_lut
  import color_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  rgb_gamma_lut_if.slave         s_axis,
  rgb_gamma_lut_if.master        m_axis,
  input  logic                   lut_we,
  input  logic [1:0]             lut_ch,
  input  logic [LUT_AW-1:0]      lut_addr,
  input  logic [LUT_W-1:0]       lut_data,
  input  logic                   lut_commit,
  output logic                   lut_pending,
  output logic                   init_done
);

`ifdef GAMMA_LUT_SHADOW_EN
  localparam int unsigned NumBanks = 2;
`else
  localparam int unsigned NumBanks = 1;
`endif

  lut_state_e        state_q, state_d;
  logic [LUT_AW-1:0] cnt_q, cnt_d;
  logic              active_q, active_d;
  logic              pending_q, pending_d;
  logic              init_done_q, init_done_d;

`ifdef GAMMA_LUT_SHADOW_EN
  logic sof;
  assign sof = s_axis.tvalid & s_axis.tuser;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    active_d    = active_q;
    pending_d   = pending_q;
    init_done_d = init_done_q;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LUT_AW'(LUT_DEPTH - 1)) begin
          state_d     = ST_RUN;
          init_done_d = 1'b1;
        end
      end
      ST_RUN: begin
`ifdef GAMMA_LUT_SHADOW_EN
        if (lut_commit) begin
          state_d   = ST_PEND;
          pending_d = 1'b1;
        end
`endif
      end
`ifdef GAMMA_LUT_SHADOW_EN
      ST_PEND: begin
        // The start-of-frame pixel seen here is the first to read the new bank.
        if (sof) begin
          state_d   = ST_RUN;
          pending_d = 1'b0;
          active_d  = ~active_q;
        end
      end
`endif
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      active_q    <= 1'b0;
      pending_q   <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      init_done_q <= init_done_d;
    end
  end

  assign lut_pending = pending_q;
  assign init_done   = init_done_q;

  // Table write port: the init sequencer owns every bank until identity is loaded.
  logic              init_wr;
  logic              wr_bank;
  logic [LUT_AW-1:0] waddr;
  logic [LUT_W-1:0]  wdata;

  always_comb begin
    init_wr = (state_q == ST_INIT);
    waddr   = init_wr ? cnt_q : lut_addr;
    wdata   = init_wr ? LUT_W'(cnt_q) : lut_data;
`ifdef GAMMA_LUT_SHADOW_EN
    wr_bank = ~active_q;
`else
    wr_bank = 1'b0;
`endif
  end

  // Pixel pipeline: stage 1 holds input and read address, stage 2 aligns with RAM data.
  pix_stage_t s1_q, s1_d, s2_q, s2_d;

  always_comb begin
    s1_d.vld = s_axis.tvalid;
    s1_d.usr = s_axis.tuser;
    s1_d.lst = s_axis.tlast;
    s1_d.byp = init_wr;
    s1_d.sel = active_d;
    s1_d.dat = s_axis.tdata;
    s2_d     = s1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  logic [NumBanks-1:0][NUM_CH-1:0][LUT_W-1:0] rd;
  logic [NUM_CH-1:0][LUT_W-1:0]               bank_rd;
  logic [PIX_W-1:0]                           lut_pix;

  for (genvar b = 0; b < NumBanks; b++) begin : g_bank
    localparam logic BankId = 1'(b);
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      logic we;
      assign we = init_wr | (lut_we & ch_hit(lut_ch, c) & (BankId == wr_bank));

      lut_bank u_lut_bank (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (wdata),
        .raddr_i (s1_q.dat[(NUM_CH-1-c)*LUT_W +: LUT_W]),
        .rdata_o (rd[b][c])
      );
    end
  end

`ifdef GAMMA_LUT_SHADOW_EN
  assign bank_rd = s2_q.sel ? rd[1] : rd[0];
  logic unused_sig;
  assign unused_sig = 1'b0;
`else
  assign bank_rd = rd[0];
  logic unused_sig;
  assign unused_sig = lut_commit ^ s2_q.sel;
`endif

  assign lut_pix = {bank_rd[0], bank_rd[1], bank_rd[2]};

  assign m_axis.tvalid = s2_q.vld;
  assign m_axis.tuser  = s2_q.usr;
  assign m_axis.tlast  = s2_q.lst;
  assign m_axis.tdata  = s2_q.byp ? s2_q.dat : lut_pix;

endmodule

// File: tb/tb_rgb_gamma_lut.sv
// Directed bench for rgb_gamma_lut: init passthrough, table writes, read-first,
// mid-line reset, line alignment and (shadow builds) frame-boundary bank swaps.
module tb_rgb_gamma_lut;

  localparam int NLINE   = 349;
  localparam int NSCREEN = 349;

  logic       clk;
  logic       rst;
  logic       lut_we;
  logic [1:0] lut_ch;
  logic [7:0] lut_addr;
  logic [7:0] lut_data;
  logic       lut_commit;
  logic       lut_pending;
  logic       init_done;

  rgb_gamma_lut_if s_if ();
  rgb_gamma_lut_if m_if ();

  rgb_gamma_lut dut (
    .clk         (clk),
    .rst         (rst),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .lut_we      (lut_we),
    .lut_ch      (lut_ch),
    .lut_addr    (lut_addr),
    .lut_data    (lut_data),
    .lut_commit  (lut_commit),
    .lut_pending (lut_pending),
    .init_done   (init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  ch;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [23:0] pix;
    logic        usr;
    logic        lst;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs [8];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [23:0] pix, input logic vld, input logic usr,
                       input logic lst);
    s_if.tvalid = vld;
    s_if.tuser  = usr;
    s_if.tlast  = lst;
    s_if.tdata  = pix;
  endtask

  task automatic lut_wr(input logic [1:0] ch, input logic [7:0] a, input logic [7:0] d);
    lut_we   = 1'b1;
    lut_ch   = ch;
    lut_addr = a;
    lut_data = d;
    step();
    lut_we   = 1'b0;
  endtask

  // One pixel in, two edges later compare data and sideband.
  task automatic send_chk(input string nm, input logic [23:0] pix, input logic usr,
                          input logic lst, input logic [23:0] exp);
    drive(pix, 1'b1, usr, lst);
    step();
    drive(24'h0, 1'b0, 1'b0, 1'b0);
    step();
    chk({nm, "_data"}, 32'(m_if.tdata), 32'(exp));
    chk({nm, "_ctrl"}, 32'({m_if.tvalid, m_if.tuser, m_if.tlast}), 32'({1'b1, usr, lst}));
  endtask

  initial begin
    logic [2:0]  prev_ctrl;
    logic [23:0] prev_dat;
    logic [2:0]  cur_ctrl;
    logic [23:0] cur_dat;
    int          p;
    int          out_cnt;

    vecs[0] = '{1'b0, 2'd0, 8'h00, 8'h00, 24'h00FF80, 1'b1, 1'b0, 24'hFFFF80};
    vecs[1] = '{1'b0, 2'd0, 8'h00, 8'h00, 24'h050505, 1'b0, 1'b0, 24'hFA0505};
    vecs[2] = '{1'b1, 2'd3, 8'h40, 8'h80, 24'h404040, 1'b0, 1'b0, 24'h808080};
    vecs[3] = '{1'b1, 2'd1, 8'h12, 8'h34, 24'h121212, 1'b0, 1'b0, 24'hED3412};
    vecs[4] = '{1'b1, 2'd2, 8'hFF, 8'h01, 24'h00FFFF, 1'b0, 1'b0, 24'hFFFF01};
    vecs[5] = '{1'b1, 2'd0, 8'h00, 8'h77, 24'h000000, 1'b0, 1'b1, 24'h770000};
    vecs[6] = '{1'b0, 2'd0, 8'h00, 8'h00, 24'h7F8081, 1'b0, 1'b0, 24'h808081};
    vecs[7] = '{1'b1, 2'd3, 8'h40, 8'h41, 24'h404040, 1'b1, 1'b1, 24'h414141};

    rst        = 1'b1;
    lut_we     = 1'b0;
    lut_ch     = 2'd0;
    lut_addr   = 8'h0;
    lut_data   = 8'h0;
    lut_commit = 1'b0;
    drive(24'h0, 1'b0, 1'b0, 1'b0);
    step();
    step();
    chk("rst_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("rst_tuser", 32'(m_if.tuser), 32'd0);
    chk("rst_tlast", 32'(m_if.tlast), 32'd0);
    chk("rst_tdata", 32'(m_if.tdata), 32'd0);
    chk("rst_pending", 32'(lut_pending), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);

    // Init: passthrough pixel sampled on edge 5, visible after edge 6.
    rst = 1'b0;
    repeat (4) step();
    drive(24'h102030, 1'b1, 1'b1, 1'b0);
    step();
    drive(24'h0, 1'b0, 1'b0, 1'b0);
    chk("init_lat1_tvalid", 32'(m_if.tvalid), 32'd0);
    step();
    chk("init_pass_data", 32'(m_if.tdata), 32'h102030);
    chk("init_pass_ctrl", 32'({m_if.tvalid, m_if.tuser}), 32'b11);
    repeat (193) step();
    lut_wr(2'd3, 8'h05, 8'hAA); // edge 200: must be ignored
    repeat (55) step();
    chk("init_done_255", 32'(init_done), 32'd0);
    step();
    chk("init_done_256", 32'(init_done), 32'd1);

`ifndef GAMMA_LUT_SHADOW_EN
    for (int k = 0; k < 256; k++) begin
      lut_wr(2'd0, 8'(k), 8'(255 - k));
    end
    for (int i = 0; i < 8; i++) begin
      if (vecs[i].wr) lut_wr(vecs[i].ch, vecs[i].addr, vecs[i].data);
      send_chk($sformatf("vec%0d", i), vecs[i].pix, vecs[i].usr, vecs[i].lst, vecs[i].exp);
    end

    // Read-first: the write lands on the same edge the RAM reads 0x20.
    drive(24'h200000, 1'b1, 1'b0, 1'b0);
    step();
    drive(24'h0, 1'b0, 1'b0, 1'b0);
    lut_wr(2'd0, 8'h20, 8'h99);
    chk("read_first_old", 32'(m_if.tdata), 32'hDF0000);
    send_chk("read_first_new", 24'h200000, 1'b0, 1'b0, 24'h990000);
`endif

    // Reset mid-line.
    for (int i = 0; i < 60; i++) begin
      drive({8'(i), 8'h11, 8'h22}, 1'b1, (i == 0), 1'b0);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    drive(24'h0, 1'b0, 1'b0, 1'b0);
    chk("midrst_tvalid", 32'(m_if.tvalid), 32'd0);
    chk("midrst_tdata", 32'(m_if.tdata), 32'd0);
    chk("midrst_init_done", 32'(init_done), 32'd0);
    chk("midrst_pending", 32'(lut_pending), 32'd0);
    repeat (255) step();
    chk("reinit_done_255", 32'(init_done), 32'd0);
    step();
    chk("reinit_done_256", 32'(init_done), 32'd1);
    send_chk("reinit_id_a", 24'h00FF80, 1'b1, 1'b0, 24'h00FF80);
    send_chk("reinit_id_b", 24'h404040, 1'b0, 1'b0, 24'h404040);
    send_chk("reinit_id_c", 24'h200512, 1'b0, 1'b1, 24'h200512);

    // Full line with idle gaps; output must equal input delayed two cycles.
    prev_ctrl = 3'b000;
    prev_dat  = 24'h0;
    p         = 0;
    out_cnt   = 0;
    for (int cyc = 0; cyc < 480; cyc++) begin
      if (p < NLINE && (cyc % 4) != 3) begin
        cur_ctrl = {1'b1, (p == 0), (p == NLINE - 1)};
        cur_dat  = {8'(p), ~8'(p), 8'(p) ^ 8'h5A};
        p++;
      end else begin
        cur_ctrl = 3'b000;
        cur_dat  = 24'hABCDEF;
      end
      drive(cur_dat, cur_ctrl[2], cur_ctrl[1], cur_ctrl[0]);
      step();
      if (m_if.tvalid) out_cnt++;
      chk("line_ctrl", 32'({m_if.tvalid, m_if.tuser, m_if.tlast}), 32'(prev_ctrl));
      if (prev_ctrl[2]) chk("line_data", 32'(m_if.tdata), 32'(prev_dat));
      prev_ctrl = cur_ctrl;
      prev_dat  = cur_dat;
    end
    drive(24'h0, 1'b0, 1'b0, 1'b0);
    chk("line_count", 32'(out_cnt), 32'(NLINE));

`ifdef GAMMA_LUT_SHADOW_EN
    // Inverted curve goes to the inactive bank; frame in flight stays identity.
    for (int k = 0; k < 256; k++) begin
      lut_wr(2'd3, 8'(k), 8'(255 - k));
    end
    send_chk("sh_pre", 24'h101010, 1'b1, 1'b0, 24'h101010);
    lut_commit = 1'b1;
    step();
    lut_commit = 1'b0;
    chk("sh_pend_rise", 32'(lut_pending), 32'd1);
    send_chk("sh_same_frame", 24'h202020, 1'b0, 1'b0, 24'h202020);
    drive(24'h101010, 1'b1, 1'b1, 1'b0);
    step();
    drive(24'h0, 1'b0, 1'b0, 1'b0);
    chk("sh_pend_fall", 32'(lut_pending), 32'd0);
    step();
    chk("sh_swapped", 32'(m_if.tdata), 32'hEFEFEF);

    // Commit coincident with tuser: this frame keeps the current bank.
    drive(24'h101010, 1'b1, 1'b1, 1'b0);
    lut_commit = 1'b1;
    step();
    lut_commit = 1'b0;
    drive(24'h0, 1'b0, 1'b0, 1'b0);
    chk("sh_coinc_pend", 32'(lut_pending), 32'd1);
    step();
    chk("sh_coinc_data", 32'(m_if.tdata), 32'hEFEFEF);
    lut_commit = 1'b1;
    step();
    lut_commit = 1'b0;
    chk("sh_second_commit", 32'(lut_pending), 32'd1);
    send_chk("sh_still_old", 24'h303030, 1'b0, 1'b0, 24'hCFCFCF);
    lut_wr(2'd0, 8'h10, 8'h55);
    drive(24'h101010, 1'b1, 1'b1, 1'b0);
    step();
    drive(24'h0, 1'b0, 1'b0, 1'b0);
    chk("sh_pend_fall2", 32'(lut_pending), 32'd0);
    step();
    chk("sh_swap_back", 32'(m_if.tdata), 32'h551010);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
